// File: rtl/tank_select_encoder.sv
// rtl/tank_select_encoder.sv - dual-rail tank-select and tank gate sequencer aligned to minor cycles
//
// Accepts a tank-access request (req/ack), drives the f7/f8 dual-rail select
// lines for SETUP_MC whole minor cycles, then opens the t_in/t_out gate for
// one whole minor cycle (two with long_word) aligned to digit 0. It also checks
// minor-cycle framing and aborts an access when framing is lost.
//
// Optional feature macro: TANK_ENC_LONG_EN (adds the long_word port).
//
// Parameters:
//   MC_LEN     digit periods per minor cycle (4..63)
//   SETUP_MC   whole minor cycles of select setup before the gate (0..3)
//
// Ports:
//   clk        digit clock
//   rst_n      asynchronous active-low reset
//   mc_last    pulse in the last digit of each minor cycle
//   req        access request level, sampled while idle
//   tank       tank number (bit0 -> f7, bit1 -> f8), latched at accept
//   dir        1 = write (t_in), 0 = read (t_out), latched at accept
//   long_word  two-minor-cycle transfer, latched at accept (TANK_ENC_LONG_EN only)
//   busy       access accepted and pending or active
//   ack        one-cycle completion pulse
//   f7_pos/f7_neg/f8_pos/f8_neg  dual-rail tank select, all 0 when idle
//   t_in/t_out gate pulses, mutually exclusive
//   sync_err   one-cycle framing-error pulse

module tank_select_encoder #(
    parameter int MC_LEN   = 18,
    parameter int SETUP_MC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mc_last,
    input  logic       req,
    input  logic [1:0] tank,
    input  logic       dir,
`ifdef TANK_ENC_LONG_EN
    input  logic       long_word,
`endif
    output logic       busy,
    output logic       ack,
    output logic       f7_pos,
    output logic       f7_neg,
    output logic       f8_pos,
    output logic       f8_neg,
    output logic       t_in,
    output logic       t_out,
    output logic       sync_err
);

    localparam int CNT_W = $clog2(MC_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Minor-cycle framing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic             locked_q;
    logic             cnt_last;
    logic             frame_err;

    assign cnt_last  = (cnt_q == CNT_W'(MC_LEN - 1));
    // While locked, the pulse and the counter's last digit must coincide.
    assign frame_err = locked_q && (mc_last != cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            // Any mc_last (first, correct or stray) re-anchors the counter.
            if (mc_last || cnt_last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // A stray pulse keeps lock (re-anchored); a missing pulse drops it.
            if (mc_last) begin
                locked_q <= 1'b1;
            end else if (cnt_last) begin
                locked_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    logic       long_in;

`ifdef TANK_ENC_LONG_EN
    assign long_in = long_word;
`else
    assign long_in = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [1:0] setup_cnt_q, setup_cnt_d;
    logic       xfer_cnt_q, xfer_cnt_d;
    logic [1:0] tank_q, tank_d;
    logic       dir_q, dir_d;
    logic       long_q, long_d;
    logic       abort;

    logic       busy_d, ack_d, t_in_d, t_out_d;
    logic       f7_pos_d, f7_neg_d, f8_pos_d, f8_neg_d;
    logic       sel_active;

    // Losing framing mid-access makes the gate alignment meaningless.
    assign abort = frame_err || !locked_q;

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        tank_d      = tank_q;
        dir_d       = dir_q;
        long_d      = long_q;

        case (state_q)
            ST_IDLE: begin
                if (req && locked_q && !frame_err) begin
                    state_d     = ST_SETUP;
                    tank_d      = tank;
                    dir_d       = dir;
                    long_d      = long_in;
                    setup_cnt_d = 2'd0;
                    xfer_cnt_d  = 1'b0;
                end
            end

            ST_SETUP: begin
                // Pulses are counted only from the cycle after accept, so a
                // pulse coinciding with accept is ignored by construction.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mc_last) begin
                    if (setup_cnt_q == 2'(SETUP_MC)) begin
                        state_d = ST_XFER;
                    end else begin
                        setup_cnt_d = setup_cnt_q + 2'd1;
                    end
                end
            end

            ST_XFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mc_last) begin
                    if (!long_q || xfer_cnt_q) begin
                        state_d = ST_DONE;
                    end else begin
                        xfer_cnt_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that every output
        // comes straight from a flop.
        sel_active = (state_d == ST_SETUP) || (state_d == ST_XFER);
        busy_d     = sel_active;
        ack_d      = (state_d == ST_DONE);
        f7_pos_d   = sel_active &&  tank_d[0];
        f7_neg_d   = sel_active && !tank_d[0];
        f8_pos_d   = sel_active &&  tank_d[1];
        f8_neg_d   = sel_active && !tank_d[1];
        t_in_d     = (state_d == ST_XFER) &&  dir_d;
        t_out_d    = (state_d == ST_XFER) && !dir_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= 2'd0;
            xfer_cnt_q  <= 1'b0;
            tank_q      <= 2'd0;
            dir_q       <= 1'b0;
            long_q      <= 1'b0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            f7_pos      <= 1'b0;
            f7_neg      <= 1'b0;
            f8_pos      <= 1'b0;
            f8_neg      <= 1'b0;
            t_in        <= 1'b0;
            t_out       <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
            tank_q      <= tank_d;
            dir_q       <= dir_d;
            long_q      <= long_d;
            busy        <= busy_d;
            ack         <= ack_d;
            f7_pos      <= f7_pos_d;
            f7_neg      <= f7_neg_d;
            f8_pos      <= f8_pos_d;
            f8_neg      <= f8_neg_d;
            t_in        <= t_in_d;
            t_out       <= t_out_d;
            sync_err    <= frame_err;
        end
    end

endmodule

// File: tb/tb_tank_select_encoder.sv
// tb/tb_tank_select_encoder.sv - randomized self-checking bench for tank_select_encoder

module tb_tank_select_encoder;

    localparam int MC  = 18;
    localparam int SMC = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mc_last;
    logic       req;
    logic [1:0] tank;
    logic       dir;
`ifdef TANK_ENC_LONG_EN
    logic       long_word;
`endif
    logic       busy, ack, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, sync_err;
    logic [8:0] dut_o;

    tank_select_encoder #(.MC_LEN(MC), .SETUP_MC(SMC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mc_last  (mc_last),
        .req      (req),
        .tank     (tank),
        .dir      (dir),
`ifdef TANK_ENC_LONG_EN
        .long_word(long_word),
`endif
        .busy     (busy),
        .ack      (ack),
        .f7_pos   (f7_pos),
        .f7_neg   (f7_neg),
        .f8_pos   (f8_pos),
        .f8_neg   (f8_neg),
        .t_in     (t_in),
        .t_out    (t_out),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    assign dut_o = {busy, ack, f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, sync_err};

    int checks = 0;
    int errors = 0;

    // Reference model: timeline of pulses and access windows in absolute cycles
    int         t;          // current cycle index since reset release
    int         a;          // cycle of the last mc_last (frame anchor)
    bit         m_locked;
    bit         txn;
    int         gs, ge;     // first and last gate cycle of the active access
    int         idle_from;  // first cycle a new request may be accepted
    logic [1:0] m_tank;
    bit         m_dir;
    int         nmc;
    logic [8:0] exp_o;
    int         mdl_acks = 0;
    int         dut_acks = 0;

    // mc_last generator
    int gen_cnt;
    bit drop_next;
    int stray_at;
    bit faults_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic bit cur_long();
`ifdef TANK_ENC_LONG_EN
        return long_word;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        t         = 0;
        a         = -1;
        m_locked  = 1'b0;
        txn       = 1'b0;
        idle_from = 0;
    endtask

    // One digit period: generate mc_last, predict, clock, compare.
    task automatic cycle(input string tag);
        bit hit, err, gate;
        int h;
        if (faults_on) begin
            if ($urandom_range(0, 399) == 0) drop_next = 1'b1;
            if ($urandom_range(0, 399) == 0 && stray_at < 0) stray_at = $urandom_range(1, 16);
        end
        mc_last = 1'b0;
        if (stray_at >= 0 && gen_cnt == stray_at) begin
            mc_last  = 1'b1;
            stray_at = -1;
            gen_cnt  = 0;
        end else if (gen_cnt == MC - 1) begin
            mc_last   = !drop_next;
            drop_next = 1'b0;
            gen_cnt   = 0;
        end else begin
            gen_cnt++;
        end

        hit   = ((t - a) % MC) == 0;
        err   = m_locked && (mc_last != hit);
        exp_o = '0;
        exp_o[0] = err;
        if (txn && err) begin
            txn       = 1'b0;
            idle_from = t + 1;
        end else if (txn) begin
            if (t + 1 <= ge) begin
                gate     = (t + 1 >= gs);
                exp_o[8] = 1'b1;
                exp_o[6] = m_tank[0];
                exp_o[5] = !m_tank[0];
                exp_o[4] = m_tank[1];
                exp_o[3] = !m_tank[1];
                exp_o[2] = gate && m_dir;
                exp_o[1] = gate && !m_dir;
            end else begin
                exp_o[7]  = 1'b1;
                txn       = 1'b0;
                idle_from = t + 2;
                mdl_acks++;
            end
        end else if (t >= idle_from && req && m_locked && !err) begin
            txn    = 1'b1;
            m_tank = tank;
            m_dir  = dir;
            nmc    = cur_long() ? 2 : 1;
            h      = t + 1;
            while (((h - a) % MC) != 0) h++;
            gs       = h + SMC * MC + 1;
            ge       = gs + nmc * MC - 1;
            exp_o[8] = 1'b1;
            exp_o[6] = tank[0];
            exp_o[5] = !tank[0];
            exp_o[4] = tank[1];
            exp_o[3] = !tank[1];
        end
        if (mc_last) begin
            a        = t;
            m_locked = 1'b1;
        end else if (hit) begin
            m_locked = 1'b0;
        end

        @(posedge clk);
        #1;
        check(tag, dut_o, exp_o);
        if (ack) dut_acks++;
        t++;
    endtask

    task automatic align(input int g);
        int n;
        n = 0;
        while (gen_cnt != g && n < 40) begin
            cycle("align");
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        mc_last   = 1'b0;
        req       = 1'b0;
        tank      = 2'b00;
        dir       = 1'b0;
`ifdef TANK_ENC_LONG_EN
        long_word = 1'b0;
`endif
        gen_cnt   = 5;
        drop_next = 1'b0;
        stray_at  = -1;
        faults_on = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", dut_o, 9'h0);
        rst_n = 1'b1;

        // Framing: lock, steady pulses, then a stray pulse at digit 10
        repeat (60) cycle("frame");
        stray_at = 10;
        repeat (60) cycle("stray");

        // Short write, tank 2, accepted 3 digits before mc_last
        align(14);
        req = 1'b1; tank = 2'b10; dir = 1'b1;
        cycle("wr_acc");
        req = 1'b0;
        repeat (60) cycle("wr");

        // Accept coincident with mc_last; req held through DONE
        align(17);
        req = 1'b1; tank = 2'b01; dir = 1'b0;
        repeat (62) cycle("coinc");
        req = 1'b0;
        repeat (60) cycle("coinc_tail");

        // Abort: withhold the closing mc_last of the transfer
        req = 1'b1; tank = 2'b01; dir = 1'b1;
        cycle("ab_acc");
        req = 1'b0;
        n = 0;
        while (!t_in && n < 80) begin
            cycle("ab_wait");
            n++;
        end
        check("ab_gate_tmo", t_in, 1);
        drop_next = 1'b1;
        req = 1'b1;
        repeat (40) cycle("abort");
        req = 1'b0;
        repeat (80) cycle("ab_tail");

`ifdef TANK_ENC_LONG_EN
        // Long word to tank 3
        req = 1'b1; tank = 2'b11; dir = 1'b1; long_word = 1'b1;
        cycle("long_acc");
        req = 1'b0; long_word = 1'b0;
        repeat (100) cycle("long");
`endif

        // Randomized traffic with occasional framing faults
        faults_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req  = ($urandom_range(0, 3) == 0);
            tank = 2'($urandom_range(0, 3));
            dir  = 1'($urandom_range(0, 1));
`ifdef TANK_ENC_LONG_EN
            long_word = 1'($urandom_range(0, 1));
`endif
            cycle("rand");
        end
        faults_on = 1'b0;
        drop_next = 1'b0;
        stray_at  = -1;

        // Asynchronous reset in the middle of a gate
        req = 1'b1; tank = 2'b10; dir = 1'b0;
        n = 0;
        while (!(t_in || t_out) && n < 200) begin
            cycle("ar_wait");
            n++;
        end
        check("ar_gate_tmo", t_in || t_out, 1);
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", dut_o, 9'h0);
        @(posedge clk);
        #1;
        check("rst_hold", dut_o, 9'h0);
        rst_n   = 1'b1;
        gen_cnt = 3;
        model_reset();
        for (int i = 0; i < 120; i++) begin
            req  = ($urandom_range(0, 2) == 0);
            tank = 2'($urandom_range(0, 3));
            dir  = 1'($urandom_range(0, 1));
            cycle("post_rst");
        end

        check("ack_count", dut_acks, mdl_acks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tank_select_encoder.md
# tank_select_encoder

Control-section sequencer that drives the dual-rail tank-select lines (f7/f8 pos/neg) and the tank in/out gate pulses consumed by the per-register tank decoders. It accepts a tank-access request (tank number, direction) via a req/ack handshake and aligns the gate to whole minor cycles of the digit clock. It also checks minor-cycle framing and aborts on framing loss. It sits between order decode/stage control and a tank_decoder2 instance.

## Interface
- MC_LEN, 18, digit periods per minor cycle; range 4..63.
- SETUP_MC, 1, full minor cycles that select lines are held before the gate opens; range 0..3.
- clk  in  1  digit clock.
- rst_n  in  1  asynchronous, active-low reset.
- mc_last  in  1  one-cycle pulse in the last digit (MC_LEN-1) of every minor cycle.
- req  in  1  access request, level, sampled when idle.
- tank  in  2  tank number, bit0 to f7 and bit1 to f8; latched at accept.
- dir  in  1  1 = write (t_in), 0 = read (t_out); latched at accept.
- long_word  in  1  two-minor-cycle transfer; latched at accept. Present only with TANK_ENC_LONG_EN.
- busy  out  1  request accepted, transfer pending or active.
- ack  out  1  one-cycle completion pulse.
- f7_pos, f7_neg, f8_pos, f8_neg  out  1 each  dual-rail select; all 0 when idle.
- t_in, t_out  out  1 each  gate pulses; mutually exclusive.
- sync_err  out  1  one-cycle framing-error pulse.

## Operation
- Reset values: every output is 0, state is IDLE, framing is unlocked, and the digit counter is 0.
- Framing:
  - Free-running digit counter counts 0..MC_LEN-1 and wraps.
  - The first mc_last after reset locks: counter goes to 0 next cycle, no error.
  - When locked, mc_last must coincide with counter==MC_LEN-1. A mismatch in either direction (pulse early, or pulse missing) pulses sync_err and unlocks. A stray mc_last re-locks on that pulse.
- States:
  - IDLE: req=1 → accept. Latch tank/dir (/long_word), set busy, enter SETUP. Select lines are driven from the next cycle: f7_pos=tank[0], f7_neg=~tank[0], f8_pos=tank[1], f8_neg=~tank[1].
  - SETUP: counts mc_last pulses, starting the cycle after accept. On pulse number SETUP_MC+1 (pulse 1 when SETUP_MC=0), go to XFER.
  - XFER: gate (t_in if dir=1, else t_out) is high for exactly MC_LEN cycles, or 2*MC_LEN if long. It closes on the edge after the final mc_last of the transfer.
  - DONE: one cycle. ack=1, busy=0, select and gate lines 0. Then IDLE.
- An mc_last in the accept cycle is not counted.
- req while busy is ignored. req held high through DONE is accepted again in the IDLE cycle after DONE.
- sync_err, or being unlocked while in SETUP/XFER, aborts the transfer:
  - All select and gate lines drop next edge, busy=0, no ack, return to IDLE.
  - New requests are not accepted until locked again.
- Asynchronous reset mid-transfer forces all outputs to 0 immediately, with no ack.

## Timing
- Accept edge to select lines valid: 1 cycle.
- Gate is aligned to digit 0 and is high through digit MC_LEN-1 of the transfer minor cycle(s).
- Select lines are stable for at least SETUP_MC*MC_LEN cycles before the gate rises, and until the gate falls.
- ack occurs in the cycle immediately after the last gate cycle.
- Worst-case latency from req to ack: (SETUP_MC+2)*MC_LEN + 2 cycles (short word).
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- TANK_ENC_LONG_EN defined:
  - long_word port exists.
  - long_word=1 holds the gate for two consecutive minor cycles (2*MC_LEN cycles, no gap); select lines are held throughout.
- TANK_ENC_LONG_EN undefined:
  - Port is absent.
  - All transfers are one minor cycle.

## Test plan
- Framing: mc_last every 18 cycles after reset. Expect no sync_err. Inject mc_last at counter 10 → sync_err exactly 1 cycle and re-lock on that pulse; next correct pulse gives no error.
- Short write, SETUP_MC=1: tank=2'b10, dir=1, req accepted 3 cycles before mc_last.
  - Select lines f7_pos=0/f7_neg=1, f8_pos=1/f8_neg=0 from cycle +1.
  - t_in high for 18 cycles, starting after the 2nd mc_last.
  - ack 1 cycle after t_in falls; t_out never asserts.
- Accept coincident with mc_last, SETUP_MC=0: that pulse is not counted, so t_out opens after the next mc_last.
  - Raise req again while busy → ignored.
  - Hold req through DONE → re-accepted in the IDLE cycle after DONE.
- Abort: withhold mc_last mid-XFER → sync_err, gate and select lines 0 next edge, busy 0, no ack. req stays ignored until the next mc_last.
- Async reset: assert rst_n=0 mid-gate → all outputs 0 without a clock edge.
- With TANK_ENC_LONG_EN: long_word=1, tank=3 → gate high for 36 contiguous cycles, select lines stable throughout, single ack.
